// File: rtl/egr_meas_event_gen.sv
// Egress measurement event generator: per-channel sequence numbering of frame
// entry/exit events, emitted as start/end records on two AXI4-Stream masters.

module egr_meas_stream #(
  parameter int CID_WIDTH  = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int SN_LSB     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ev_acc,
  input  logic [CID_WIDTH-1:0] ev_cid,
  input  logic                 clr_busy,
  input  logic [CID_WIDTH-1:0] clr_idx,
  output logic                 tvalid,
  input  logic                 tready,
  output logic [135:0]         tdata,
  output logic [31:0]          drop_cnt
);
  localparam int ENTRIES = 1 << CID_WIDTH;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int REC_W   = CID_WIDTH + 32;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [31:0]          sn_tbl [ENTRIES];
  logic [REC_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic                 vld_p0, vld_p1;
  logic [CID_WIDTH-1:0] cid_p0, cid_p1;
  logic [31:0]          rd_p0, sn_p1, sn_cur;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, pop, push, drop;
  logic [REC_W-1:0]     head;

  // p1 still holds the previous same-channel write that the table read missed
  assign sn_cur = (vld_p1 && (cid_p1 == cid_p0)) ? sn_p1 + 32'd1 : rd_p0;

  assign tvalid = (wr_ptr != rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = tvalid & tready;
  assign push   = vld_p1 & (~full | pop);
  assign drop   = vld_p1 & full & ~pop;
  assign head   = fifo_mem[rd_ptr[AW-1:0]];

  always_comb begin
    tdata                  = '0;
    tdata[CID_WIDTH-1:0]   = head[CID_WIDTH-1:0];
    tdata[SN_LSB +: 32]    = head[CID_WIDTH +: 32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      vld_p0 <= ev_acc;
      vld_p1 <= vld_p0;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Stage p0: table read; stage p1: SN assigned; stage p2: FIFO push
  always_ff @(posedge clk) begin
    cid_p0 <= ev_cid;
    rd_p0  <= sn_tbl[ev_cid];
    cid_p1 <= cid_p0;
    sn_p1  <= sn_cur;
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {sn_p1, cid_p1};
  end

  // Sweep write is placed last so it overrides a same-cycle write-back
  always_ff @(posedge clk) begin
    if (vld_p0)   sn_tbl[cid_p0]  <= sn_cur + 32'd1;
    if (clr_busy) sn_tbl[clr_idx] <= '0;
  end
endmodule

module egr_meas_event_gen #(
  parameter int CID_WIDTH  = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 cfg_enable,
  input  logic                 cfg_sn_clear,
  output logic                 sn_clear_busy,
  input  logic                 frm_start_valid,
  input  logic [CID_WIDTH-1:0] frm_start_cid,
  input  logic                 frm_end_valid,
  input  logic [CID_WIDTH-1:0] frm_end_cid,
  output logic                 egr_meas_start_tvalid,
  input  logic                 egr_meas_start_tready,
  output logic [135:0]         egr_meas_start_tdata,
  output logic                 egr_meas_end_tvalid,
  input  logic                 egr_meas_end_tready,
  output logic [135:0]         egr_meas_end_tdata,
  output logic [31:0]          start_drop_cnt,
  output logic [31:0]          end_drop_cnt
);
  typedef enum logic [1:0] {CLR_INIT, CLR_IDLE, CLR_SWEEP} clr_state_t;

  clr_state_t           clr_state;
  logic [CID_WIDTH-1:0] clr_idx;
  logic                 start_acc, end_acc;

  assign start_acc = frm_start_valid & cfg_enable & ~sn_clear_busy;
  assign end_acc   = frm_end_valid   & cfg_enable & ~sn_clear_busy;

  // Reset lands in CLR_INIT so the tables are swept to zero right after reset
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      clr_state     <= CLR_INIT;
      sn_clear_busy <= 1'b0;
      clr_idx       <= '0;
    end else begin
      unique case (clr_state)
        CLR_INIT: begin
          clr_state     <= CLR_SWEEP;
          sn_clear_busy <= 1'b1;
          clr_idx       <= '0;
        end
        CLR_IDLE: begin
          if (cfg_sn_clear) begin
            clr_state     <= CLR_SWEEP;
            sn_clear_busy <= 1'b1;
            clr_idx       <= '0;
          end
        end
        CLR_SWEEP: begin
          clr_idx <= clr_idx + CID_WIDTH'(1);
          if (&clr_idx) begin
            clr_state     <= CLR_IDLE;
            sn_clear_busy <= 1'b0;
          end
        end
        default: clr_state <= CLR_IDLE;
      endcase
    end
  end

  egr_meas_stream #(.CID_WIDTH(CID_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .SN_LSB(64)) u_start (
    .clk(ap_clk), .rst(ap_rst), .ev_acc(start_acc), .ev_cid(frm_start_cid),
    .clr_busy(sn_clear_busy), .clr_idx(clr_idx),
    .tvalid(egr_meas_start_tvalid), .tready(egr_meas_start_tready),
    .tdata(egr_meas_start_tdata), .drop_cnt(start_drop_cnt)
  );

  egr_meas_stream #(.CID_WIDTH(CID_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .SN_LSB(32)) u_end (
    .clk(ap_clk), .rst(ap_rst), .ev_acc(end_acc), .ev_cid(frm_end_cid),
    .clr_busy(sn_clear_busy), .clr_idx(clr_idx),
    .tvalid(egr_meas_end_tvalid), .tready(egr_meas_end_tready),
    .tdata(egr_meas_end_tdata), .drop_cnt(end_drop_cnt)
  );
endmodule

// File: tb/tb_egr_meas_event_gen.sv
// Scoreboard bench for egr_meas_event_gen: a bench-side SN model queues expected
// records at stimulus time; a negedge monitor pops and compares on every beat.

module tb_egr_meas_event_gen;
  localparam int CW    = 10;
  localparam int DEPTH = 16;
  localparam int ENT   = 1 << CW;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          cfg_enable, cfg_sn_clear, sn_clear_busy;
  logic          frm_start_valid, frm_end_valid;
  logic [CW-1:0] frm_start_cid, frm_end_cid;
  logic          egr_meas_start_tvalid, egr_meas_start_tready;
  logic [135:0]  egr_meas_start_tdata;
  logic          egr_meas_end_tvalid, egr_meas_end_tready;
  logic [135:0]  egr_meas_end_tdata;
  logic [31:0]   start_drop_cnt, end_drop_cnt;

  egr_meas_event_gen #(.CID_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cfg_enable(cfg_enable), .cfg_sn_clear(cfg_sn_clear), .sn_clear_busy(sn_clear_busy),
    .frm_start_valid(frm_start_valid), .frm_start_cid(frm_start_cid),
    .frm_end_valid(frm_end_valid), .frm_end_cid(frm_end_cid),
    .egr_meas_start_tvalid(egr_meas_start_tvalid), .egr_meas_start_tready(egr_meas_start_tready),
    .egr_meas_start_tdata(egr_meas_start_tdata),
    .egr_meas_end_tvalid(egr_meas_end_tvalid), .egr_meas_end_tready(egr_meas_end_tready),
    .egr_meas_end_tdata(egr_meas_end_tdata),
    .start_drop_cnt(start_drop_cnt), .end_drop_cnt(end_drop_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           exp_st_drop = 0;
  logic [31:0]  m_st [ENT];
  logic [31:0]  m_en [ENT];
  logic [135:0] st_q[$];
  logic [135:0] en_q[$];
  int           st_bc[$];
  int           en_bc[$];

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [135:0] mk(input int cid, input logic [31:0] sn, input int lsb);
    logic [135:0] r;
    r = '0;
    r[CW-1:0] = cid[CW-1:0];
    r[lsb +: 32] = sn;
    return r;
  endfunction

  always @(negedge ap_clk) begin
    if (ap_rst === 1'b0) begin
      if (egr_meas_start_tvalid && egr_meas_start_tready) begin
        st_bc.push_back(cyc);
        if (st_q.size() == 0) chk("start_unexpected_beat", egr_meas_start_tdata, 136'(0));
        else chk("start_beat", egr_meas_start_tdata, st_q.pop_front());
      end
      if (egr_meas_end_tvalid && egr_meas_end_tready) begin
        en_bc.push_back(cyc);
        if (en_q.size() == 0) chk("end_unexpected_beat", egr_meas_end_tdata, 136'(0));
        else chk("end_beat", egr_meas_end_tdata, en_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic reset_model();
    for (int i = 0; i < ENT; i++) begin
      m_st[i] = '0;
      m_en[i] = '0;
    end
  endtask

  task automatic drive(input bit sv, input int scid, input bit ev, input int ecid, input bit acc);
    frm_start_valid = sv;
    frm_start_cid   = scid[CW-1:0];
    frm_end_valid   = ev;
    frm_end_cid     = ecid[CW-1:0];
    if (acc && sv) begin
      if (!egr_meas_start_tready && st_q.size() >= DEPTH) exp_st_drop++;
      else st_q.push_back(mk(scid, m_st[scid], 64));
      m_st[scid] = m_st[scid] + 32'd1;
    end
    if (acc && ev) begin
      en_q.push_back(mk(ecid, m_en[ecid], 32));
      m_en[ecid] = m_en[ecid] + 32'd1;
    end
    tick();
    frm_start_valid = 1'b0;
    frm_end_valid   = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((st_q.size() + en_q.size()) != 0 && t < 200) begin
      tick();
      t++;
    end
    chk(tag, 136'(st_q.size() + en_q.size()), 136'(0));
    idle(2);
  endtask

  task automatic wait_sweep(input string tag, input int exp_len);
    int n;
    n = 0;
    for (int k = 0; k < ENT + 16; k++) begin
      @(negedge ap_clk);
      if (sn_clear_busy === 1'b1) n++;
      else if (n > 0) break;
    end
    chk(tag, 136'(n), 136'(exp_len));
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ev_c;
    ap_rst = 1'b1;
    cfg_enable = 1'b0;
    cfg_sn_clear = 1'b0;
    frm_start_valid = 1'b0;
    frm_end_valid = 1'b0;
    frm_start_cid = '0;
    frm_end_cid = '0;
    egr_meas_start_tready = 1'b1;
    egr_meas_end_tready = 1'b1;
    idle(3);
    @(negedge ap_clk);
    chk("rst_start_tvalid", 136'(egr_meas_start_tvalid), 136'(0));
    chk("rst_end_tvalid", 136'(egr_meas_end_tvalid), 136'(0));
    chk("rst_busy", 136'(sn_clear_busy), 136'(0));
    chk("rst_start_drop", 136'(start_drop_cnt), 136'(0));
    chk("rst_end_drop", 136'(end_drop_cnt), 136'(0));
    tick();
    ap_rst = 1'b0;
    reset_model();
    wait_sweep("reset_sweep_len", ENT);
    cfg_enable = 1'b1;

    // Three back-to-back same-channel start events
    st_bc.delete();
    ev_c = cyc;
    repeat (3) drive(1, 5, 0, 0, 1);
    wait_drain("t1_drain");
    chk("t1_beat_count", 136'(st_bc.size()), 136'(3));
    chk("t1_latency", 136'(st_bc[0] - ev_c), 136'(3));

    // Every-other-cycle same channel
    drive(1, 5, 0, 0, 1);
    idle(1);
    drive(1, 5, 0, 0, 1);
    wait_drain("t1b_drain");

    // Simultaneous start and end on one channel
    st_bc.delete();
    en_bc.delete();
    ev_c = cyc;
    drive(1, 7, 1, 7, 1);
    wait_drain("t2_drain");
    chk("t2_start_latency", 136'(st_bc[0] - ev_c), 136'(3));
    chk("t2_end_latency", 136'(en_bc[0] - ev_c), 136'(3));

    // Events ignored while disabled
    cfg_enable = 1'b0;
    drive(1, 5, 1, 5, 0);
    cfg_enable = 1'b1;
    drive(1, 5, 1, 5, 1);
    wait_drain("t_en_drain");

    // Mixed traffic with random backpressure
    for (int i = 0; i < 12; i++) begin
      egr_meas_start_tready = ($urandom_range(0, 3) != 0);
      egr_meas_end_tready   = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
            1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 1);
    end
    egr_meas_start_tready = 1'b1;
    egr_meas_end_tready = 1'b1;
    wait_drain("t_rand_drain");

    // Overflow with tready low
    egr_meas_start_tready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) drive(1, 9, 0, 0, 1);
    idle(4);
    @(negedge ap_clk);
    chk("t3_tvalid_held", 136'(egr_meas_start_tvalid), 136'(1));
    chk("t3_head", egr_meas_start_tdata, st_q[0]);
    chk("t3_drop_cnt", 136'(start_drop_cnt), 136'(exp_st_drop));
    tick();
    idle(3);
    @(negedge ap_clk);
    chk("t3_head_stable", egr_meas_start_tdata, st_q[0]);
    tick();
    egr_meas_start_tready = 1'b1;
    wait_drain("t3_drain");
    drive(1, 9, 0, 0, 1);
    wait_drain("t3_next_drain");
    chk("t3_drop_final", 136'(start_drop_cnt), 136'(3));
    chk("t3_end_drop", 136'(end_drop_cnt), 136'(0));

    // SN wrap on channel 2
    @(negedge ap_clk);
    dut.u_start.sn_tbl[2] <= 32'hFFFF_FFFF;
    m_st[2] = 32'hFFFF_FFFF;
    tick();
    drive(1, 2, 0, 0, 1);
    drive(1, 2, 0, 0, 1);
    wait_drain("t4_drain");

    // Clear sweep: event just before the pulse, one during the sweep
    drive(1, 4, 1, 4, 1);
    drive(1, 4, 1, 4, 1);
    drive(1, 4, 1, 4, 1);
    cfg_sn_clear = 1'b1;
    tick();
    cfg_sn_clear = 1'b0;
    @(negedge ap_clk);
    chk("t5_busy_rise", 136'(sn_clear_busy), 136'(1));
    tick();
    drive(1, 4, 1, 4, 0);
    cfg_sn_clear = 1'b1;
    tick();
    cfg_sn_clear = 1'b0;
    wait_sweep("t5_sweep_len", ENT - 3);
    reset_model();
    wait_drain("t5_drain");
    drive(1, 4, 1, 4, 1);
    drive(1, 7, 0, 0, 1);
    wait_drain("t5_post_drain");

    // Reset with records queued and in flight
    egr_meas_start_tready = 1'b0;
    egr_meas_end_tready = 1'b0;
    repeat (4) drive(1, 11, 1, 11, 1);
    idle(3);
    repeat (2) drive(1, 11, 1, 11, 1);
    ap_rst = 1'b1;
    tick();
    @(negedge ap_clk);
    chk("t6_start_tvalid", 136'(egr_meas_start_tvalid), 136'(0));
    chk("t6_end_tvalid", 136'(egr_meas_end_tvalid), 136'(0));
    chk("t6_start_drop", 136'(start_drop_cnt), 136'(0));
    chk("t6_busy", 136'(sn_clear_busy), 136'(0));
    tick();
    st_q.delete();
    en_q.delete();
    st_bc.delete();
    en_bc.delete();
    exp_st_drop = 0;
    reset_model();
    ap_rst = 1'b0;
    egr_meas_start_tready = 1'b1;
    egr_meas_end_tready = 1'b1;
    wait_sweep("t6_sweep_len", ENT);
    idle(10);
    chk("t6_no_stale_start", 136'(st_bc.size()), 136'(0));
    chk("t6_no_stale_end", 136'(en_bc.size()), 136'(0));
    drive(1, 11, 1, 11, 1);
    wait_drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
